// File: rtl/agc_pack_pkg.sv
// Shared widths and FIFO entry layout for the AGC stream packer.
// No logic here: types and constants only.
package agc_pack_pkg;

    localparam int SAMPLE_BITS     = 5;
    localparam int SAMPLES_PER_CLK = 8;
    localparam int IN_W            = SAMPLE_BITS * SAMPLES_PER_CLK;
    localparam int OUT_W           = 128;
    localparam int ACC_W           = 168;

    typedef struct packed {
        logic             tlast;
        logic [OUT_W-1:0] tdata;
    } fifo_entry_t;

endpackage

// File: rtl/agc_pack_fifo.sv
// First-word-fall-through FIFO; rd_dat is 0 while empty. Latency: write to rd_vld 1 clk.
// Backpressure: caller must not write when full unless it pops in the same cycle.
module agc_pack_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld = ~empty;
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_vld)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_rdy && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; the empty gate on rd_dat hides stale contents.
    always_ff @(posedge aclk) begin
        if (wr_vld)
            mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/agc_stream_packer.sv
// Gearbox 40b/clk AGC samples into 128b AXI4-Stream words (tlast with AGC_PACK_TLAST_EN); dat_i to tvalid 1 clk.
// Backpressure: FWFT FIFO absorbs stalls; a word emitted into a full FIFO is dropped and counted.
module agc_stream_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DROP_CNT_W  = 16,
    parameter int TLAST_BEATS = 5
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  en_i,
    input  logic [39:0]           dat_i,
    input  logic                  clr_i,
    output logic [127:0]          m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
`ifdef AGC_PACK_TLAST_EN
    output logic                  m_axis_tlast,
`endif
    output logic                  overflow_o,
    output logic [DROP_CNT_W-1:0] drop_count_o
);
    import agc_pack_pkg::*;

    localparam logic [7:0] IN_STEP  = 8'(IN_W);
    localparam logic [7:0] OUT_STEP = 8'(OUT_W);

    if (FIFO_DEPTH < 2 || TLAST_BEATS < 1) begin : g_bad_param
        $error("agc_stream_packer: FIFO_DEPTH must be >=2 and TLAST_BEATS >=1");
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] t;
    logic [7:0]       fill;
    logic             emit;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        t    = acc | (ACC_W'(dat_i) << fill);
        emit = en_i && ((fill + IN_STEP) >= OUT_STEP);
    end

    // fill stays a multiple of 8 and never exceeds 120, so 8 bits hold fill+40.
    always_ff @(posedge aclk) begin
        if (!aresetn || !en_i) begin
            acc  <= '0;
            fill <= '0;
        end else if (emit) begin
            acc  <= t >> OUT_W;
            fill <= fill + IN_STEP - OUT_STEP;
        end else begin
            acc  <= t;
            fill <= fill + IN_STEP;
        end
    end

    assign pop  = m_axis_tvalid & m_axis_tready;
    assign push = emit & (~fifo_full | pop);
    assign drop = emit & fifo_full & ~pop;

`ifdef AGC_PACK_TLAST_EN
    localparam int CNT_W = $clog2(TLAST_BEATS + 1);

    logic [CNT_W-1:0] word_cnt;
    fifo_entry_t      wr_ent;
    fifo_entry_t      rd_ent;

    // Counts every emitted word, dropped or not, so packet framing tracks input beats.
    always_ff @(posedge aclk) begin
        if (!aresetn || !en_i)
            word_cnt <= '0;
        else if (emit)
            word_cnt <= (word_cnt == CNT_W'(TLAST_BEATS - 1)) ? '0 : word_cnt + 1'b1;
    end

    assign wr_ent.tlast  = (word_cnt == CNT_W'(TLAST_BEATS - 1));
    assign wr_ent.tdata  = t[OUT_W-1:0];
    assign m_axis_tdata  = rd_ent.tdata;
    assign m_axis_tlast  = rd_ent.tlast;
`else
    logic [OUT_W-1:0] wr_ent;
    logic [OUT_W-1:0] rd_ent;

    assign wr_ent       = t[OUT_W-1:0];
    assign m_axis_tdata = rd_ent;
`endif

    agc_pack_fifo #(
        .W     ($bits(wr_ent)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_vld  (push),
        .wr_dat  (wr_ent),
        .full    (fifo_full),
        .rd_rdy  (m_axis_tready),
        .rd_vld  (m_axis_tvalid),
        .rd_dat  (rd_ent)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (drop) begin
            overflow_o   <= 1'b1;
            if (clr_i)
                drop_count_o <= DROP_CNT_W'(1);
            else if (!(&drop_count_o))
                drop_count_o <= drop_count_o + 1'b1;
        end else if (clr_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end
    end

endmodule

// File: tb/tb_agc_stream_packer.sv
// Directed bench for agc_stream_packer: bit-serial reference model feeds a word scoreboard.
// Words leaving the AXI port are popped and compared at the falling edge.
module tb_agc_stream_packer;

    localparam int FIFO_DEPTH  = 4;
    localparam int DROP_CNT_W  = 16;
    localparam int TLAST_BEATS = 5;

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic                  en_i;
    logic [39:0]           dat_i;
    logic                  clr_i;
    logic [127:0]          m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
`ifdef AGC_PACK_TLAST_EN
    logic                  m_axis_tlast;
`endif
    logic                  overflow_o;
    logic [DROP_CNT_W-1:0] drop_count_o;

    always #5 aclk = ~aclk;

    agc_stream_packer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .DROP_CNT_W  (DROP_CNT_W),
        .TLAST_BEATS (TLAST_BEATS)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .en_i          (en_i),
        .dat_i         (dat_i),
        .clr_i         (clr_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef AGC_PACK_TLAST_EN
        .m_axis_tlast  (m_axis_tlast),
`endif
        .overflow_o    (overflow_o),
        .drop_count_o  (drop_count_o)
    );

    int tests  = 0;
    int fails  = 0;
    int hs_cnt = 0;
    int tl_cnt = 0;
    int hs0;
    int tl0;

    logic [128:0] exp_q [$];
    logic [128:0] mon_e;

    logic [127:0] wbuf;
    int           nbits;
    int           m_occ;
    int           m_wc;
    logic         m_ovf;
    logic [15:0]  m_drop;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [39:0] rnd40();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[39:0];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        wbuf   = '0;
        nbits  = 0;
        m_occ  = 0;
        m_wc   = 0;
        m_ovf  = 1'b0;
        m_drop = '0;
    endtask

    // One clock of stimulus; the model appends input bits one at a time into a 128-bit word.
    task automatic step(input logic en, input logic [39:0] d, input logic rdy, input logic clr);
        logic         pop;
        logic         emit;
        logic         lastb;
        logic         dropped;
        logic [127:0] w;
        en_i          = en;
        dat_i         = d;
        m_axis_tready = rdy;
        clr_i         = clr;
        pop   = (m_occ > 0) && rdy;
        emit  = 1'b0;
        lastb = 1'b0;
        w     = '0;
        if (en) begin
            for (int b = 0; b < 40; b++) begin
                wbuf[nbits] = d[b];
                nbits++;
                if (nbits == 128) begin
                    w     = wbuf;
                    wbuf  = '0;
                    nbits = 0;
                    emit  = 1'b1;
                end
            end
        end else begin
            wbuf  = '0;
            nbits = 0;
            m_wc  = 0;
        end
        if (emit) begin
            lastb = (m_wc == TLAST_BEATS - 1);
            m_wc  = (m_wc + 1) % TLAST_BEATS;
        end
        dropped = emit && !(m_occ < FIFO_DEPTH || pop);
        if (emit && !dropped) begin
            exp_q.push_back({lastb, w});
            m_occ++;
        end
        if (dropped) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = '0;
        end
        if (pop)
            m_occ--;
        @(posedge aclk);
        #1;
        clr_i = 1'b0;
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        en_i          = 1'b0;
        clr_i         = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge aclk);
        #1;
        model_clear();
    endtask

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            hs_cnt++;
`ifdef AGC_PACK_TLAST_EN
            if (m_axis_tlast === 1'b1)
                tl_cnt++;
`endif
            tests++;
            assert (exp_q.size() > 0)
            else begin
                fails++;
                $error("FAIL sb_unexpected observed=word %0h expected=no word", m_axis_tdata);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_tdata", m_axis_tdata, mon_e[127:0]);
`ifdef AGC_PACK_TLAST_EN
                chk("sb_tlast", {127'b0, m_axis_tlast}, {127'b0, mon_e[128]});
`endif
            end
        end
    end

    initial begin
        logic [127:0] expw;
        aresetn       = 1'b0;
        en_i          = 1'b0;
        dat_i         = '0;
        clr_i         = 1'b0;
        m_axis_tready = 1'b0;
        model_clear();
        do_reset();
        do_reset();
        aresetn = 1'b1;

        chk("rst_tvalid", {127'b0, m_axis_tvalid}, 128'd0);
        chk("rst_tdata", m_axis_tdata, 128'd0);
        chk("rst_overflow", {127'b0, overflow_o}, 128'd0);
        chk("rst_drop_count", {112'b0, drop_count_o}, 128'd0);

        // Beat ordering and 1-cycle latency
        step(1'b1, 40'h1, 1'b1, 1'b0);
        step(1'b1, 40'h2, 1'b1, 1'b0);
        step(1'b1, 40'h3, 1'b1, 1'b0);
        chk("order_tvalid_early", {127'b0, m_axis_tvalid}, 128'd0);
        step(1'b1, 40'h4, 1'b1, 1'b0);
        expw = 128'h1 | (128'h2 << 40) | (128'h3 << 80) | (128'h4 << 120);
        chk("order_tvalid", {127'b0, m_axis_tvalid}, 128'd1);
        chk("order_tdata", m_axis_tdata, expw);
        step(1'b0, 40'h0, 1'b1, 1'b0);
        step(1'b0, 40'h0, 1'b1, 1'b0);

        // Rate: 16 beats give 5 words
        hs0 = hs_cnt;
        for (int i = 0; i < 16; i++) step(1'b1, 40'hFF_FFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 40'h0, 1'b1, 1'b0);
        chk("rate_words", 128'(hs_cnt - hs0), 128'd5);
        chk("rate_overflow", {127'b0, overflow_o}, 128'd0);

        // Overflow with FIFO stalled
        for (int i = 0; i < 64; i++) step(1'b1, rnd40(), 1'b0, 1'b0);
        chk("ovf_drop_count", {112'b0, drop_count_o}, 128'd16);
        chk("ovf_flag", {127'b0, overflow_o}, 128'd1);
        chk("ovf_tvalid_held", {127'b0, m_axis_tvalid}, 128'd1);
        hs0 = hs_cnt;
        for (int i = 0; i < 4; i++) step(1'b0, 40'h0, 1'b1, 1'b0);
        chk("ovf_drain_words", 128'(hs_cnt - hs0), 128'd4);
        chk("ovf_drain_empty", {127'b0, m_axis_tvalid}, 128'd0);

        // Clear coinciding with a drop: the drop wins
        step(1'b0, 40'h0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, rnd40(), 1'b0, 1'b0);
        step(1'b1, rnd40(), 1'b0, 1'b1);
        chk("clr_race_count", {112'b0, drop_count_o}, 128'd1);
        chk("clr_race_flag", {127'b0, overflow_o}, 128'd1);
        step(1'b0, 40'h0, 1'b0, 1'b1);
        chk("clr_count", {112'b0, drop_count_o}, 128'd0);
        chk("clr_flag", {127'b0, overflow_o}, 128'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 40'h0, 1'b1, 1'b0);

        // Enable drop discards partial word
        for (int i = 0; i < 3; i++) step(1'b1, rnd40(), 1'b1, 1'b0);
        step(1'b0, 40'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 40'h5, 1'b1, 1'b0);
        expw = 128'h5 | (128'h5 << 40) | (128'h5 << 80) | (128'h5 << 120);
        chk("reen_tvalid", {127'b0, m_axis_tvalid}, 128'd1);
        chk("reen_tdata", m_axis_tdata, expw);
        step(1'b0, 40'h0, 1'b1, 1'b0);
        step(1'b0, 40'h0, 1'b1, 1'b0);

        // Mid-stream reset flushes FIFO
        for (int i = 0; i < 10; i++) step(1'b1, rnd40(), 1'b0, 1'b0);
        chk("mrst_tvalid_pre", {127'b0, m_axis_tvalid}, 128'd1);
        do_reset();
        chk("mrst_tvalid", {127'b0, m_axis_tvalid}, 128'd0);
        chk("mrst_tdata", m_axis_tdata, 128'd0);
        aresetn = 1'b1;
        hs0 = hs_cnt;
        step(1'b0, 40'h0, 1'b1, 1'b0);
        step(1'b0, 40'h0, 1'b1, 1'b0);
        chk("mrst_empty_words", 128'(hs_cnt - hs0), 128'd0);
        chk("mrst_empty_tvalid", {127'b0, m_axis_tvalid}, 128'd0);

`ifdef AGC_PACK_TLAST_EN
        hs0 = hs_cnt;
        tl0 = tl_cnt;
        for (int i = 0; i < 32; i++) step(1'b1, rnd40(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 40'h0, 1'b1, 1'b0);
        chk("tlast_words", 128'(hs_cnt - hs0), 128'd10);
        chk("tlast_count", 128'(tl_cnt - tl0), 128'd2);
        tl0 = tl_cnt;
        for (int i = 0; i < 16; i++) step(1'b1, rnd40(), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, rnd40(), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 40'h0, 1'b1, 1'b0);
        chk("tlast_drop_count", 128'(tl_cnt - tl0), 128'd1);
`else
        tl0 = tl_cnt;
        hs0 = hs_cnt;
`endif

        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
